seg7_encoder: RTL
=================

SEG7_ENCODER -- requirements
Module: seg7_encoder

Interface
REQ-001 Parameter WIDTH, default `WORD_SIZE_p, input word width in bits (>=4).
REQ-002 Parameter DIGITS, default 3, number of 7-segment digit positions driven (>=1).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  in_data valid this cycle.
REQ-006 Port in_ready  output  1  encoder can accept a word this cycle.
REQ-007 Port in_data  input  WIDTH  binary value to display.
REQ-008 Port out_valid  output  1  one-cycle pulse, new out_seg/out_ovf valid.
REQ-009 Port out_seg  output  8*DIGITS  active-low segment patterns; digit k at bits [8k+7:8k], digit 0 least significant.
REQ-010 Port out_ovf  output  1  last result did not fit DIGITS positions.

Function
REQ-011 FSM states IDLE, CONV, DONE; in_ready SHALL equal (state==IDLE).
REQ-012 Accept SHALL occur when in_valid && in_ready; IDLE->CONV, magnitude latched, BCD accumulator cleared, bit counter loaded with WIDTH.
REQ-013 CONV SHALL perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift in next magnitude MSB) for exactly WIDTH cycles, then ->DONE.
REQ-014 Internal BCD digit count SHALL be BCD_DIGITS = (WIDTH*77)/256 + 1, independent of DIGITS.
REQ-015 In DONE, out_seg and out_ovf SHALL be registered, out_valid SHALL be 1 for that cycle only, next state IDLE.
REQ-016 Latency: accept at edge t -> out_valid high in cycle t+WIDTH+1; throughput one word per WIDTH+2 cycles.
REQ-017 out_seg/out_ovf SHALL hold their value until the next DONE.
REQ-018 Leading-zero blanking: every digit above the most significant nonzero digit SHALL be OFF (8'hFF); digit 0 always shown (value 0 -> ZERO 8'hC0).
REQ-019 Overflow: if any nonzero BCD digit lies at index >= DIGITS, every position SHALL show MINUS (8'hBF) and out_ovf SHALL be 1.
REQ-020 Digit codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90 (hex).
REQ-021 in_valid during CONV/DONE SHALL be ignored; no data is captured.

Reset
REQ-022 rst_n low SHALL force state IDLE, out_valid 0, out_ovf 0, out_seg all 8'hFF, counters and accumulator 0, asynchronously, including mid-CONV (conversion discarded, no out_valid).
REQ-023 First accept SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-024 Macro SEG7_SIGNED_EN defined: in_data is two's complement; negative input converted as magnitude (negation at accept, no extra latency; -2^(WIDTH-1) handled); MINUS placed in the position directly above the most significant digit; if magnitude uses all DIGITS positions, overflow per REQ-019.
REQ-025 Macro SEG7_SIGNED_EN undefined: in_data is unsigned; no sign logic present.

Structure
REQ-026 Package seg7_pkg SHALL hold the segment-code constants (including MINUS, OFF), the FSM state enum and the BCD_DIGITS formula function.
REQ-027 Sub-module seg7_digit_lut (4-bit BCD in, 8-bit pattern out, non-BCD -> OFF) SHALL be instantiated once per displayed digit.

Verification (WIDTH=8, DIGITS=3 unless noted)
REQ-028 Accept 0 -> 9 cycles later out_valid pulse, out_seg FF_FF_C0, out_ovf 0.
REQ-029 Accept 255 then 7 with in_valid held high -> A4_92_92, then FF_FF_F8; second accept only in IDLE, 10 cycles apart.
REQ-030 DIGITS=2, accept 100 -> out_seg BF_BF, out_ovf 1; then 42 -> 99_A4, out_ovf 0.
REQ-031 SEG7_SIGNED_EN: 8'hF9 -> FF_BF_F8; 8'h80 -> BF_BF_BF, out_ovf 1; 8'h7F -> F9_A4_F8.
REQ-032 rst_n pulsed low in 4th CONV cycle -> no out_valid, out_seg FF_FF_FF, in_ready 1 after release, next accept of 5 -> FF_FF_92.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the binary-to-7-segment encoder: segment codes, FSM states, BCD sizing.
// Supplies a default for `WORD_SIZE_p when the build does not define it.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif

package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // log10(2) ~= 77/256, so this is enough decimal digits for any WIDTH-bit magnitude
    function automatic int bcd_digits(input int width);
        return (width * 77) / 256 + 1;
    endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// One BCD digit to active-low 7-segment pattern; codes above 9 blank the digit.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Decode one BCD nibble
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_encoder.sv
// Serial double-dabble binary-to-BCD converter driving DIGITS 7-segment positions.
// Define SEG7_SIGNED_EN to treat in_data as two's complement and show a leading minus.
module seg7_encoder
    import seg7_pkg::*;
#(
    parameter int WIDTH  = `WORD_SIZE_p,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic [8*DIGITS-1:0]   out_seg,
    output logic                  out_ovf
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH + 1);

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     mag_r;
    logic [BCD_W-1:0]     bcd_r;
    logic [BCD_W-1:0]     adj_s;
    logic [BCD_W-1:0]     bcd_step_s;
    logic [8*DIGITS-1:0]  lut_s;
    logic [8*DIGITS-1:0]  seg_s;
    logic                 accept_s;
    logic                 last_step_s;
    logic                 neg_s;
    logic                 big_s;
    logic                 ovf_s;
    int                   msd_s;

    assign accept_s    = in_valid & in_ready;
    assign last_step_s = (cnt_r == CNT_W'(1));

`ifdef SEG7_SIGNED_EN
    logic neg_r;

    // Sign of the word under conversion, captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (state_r == ST_IDLE && accept_s) begin
            neg_r <= in_data[WIDTH-1];
        end
    end

    assign neg_s = neg_r;
`else
    assign neg_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_CONV;
                else          state_s = ST_IDLE;
            end
            ST_CONV: begin
                if (last_step_s) state_s = ST_DONE;
                else             state_s = ST_CONV;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_r == ST_IDLE);
    end

    // One double-dabble step: add-3 correction, then shift in the next magnitude bit
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            else                         adj_s[4*i +: 4] = bcd_r[4*i +: 4];
        end
        bcd_step_s = {adj_s[BCD_W-2:0], mag_r[WIDTH-1]};
    end

    // Conversion datapath: magnitude shifter, BCD accumulator, step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef SEG7_SIGNED_EN
                        // -2^(WIDTH-1) negates to itself, which is the right unsigned magnitude
                        mag_r <= in_data[WIDTH-1] ? (~in_data + {{(WIDTH-1){1'b0}}, 1'b1}) : in_data;
`else
                        mag_r <= in_data;
`endif
                        bcd_r <= '0;
                        cnt_r <= CNT_W'(WIDTH);
                    end
                end
                ST_CONV: begin
                    bcd_r <= bcd_step_s;
                    mag_r <= {mag_r[WIDTH-2:0], 1'b0};
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_lut
            if (k < BCD_DIGITS) begin : g_bcd
                seg7_digit_lut u_lut (.bcd(bcd_step_s[4*k +: 4]), .seg(lut_s[8*k +: 8]));
            end else begin : g_pad
                seg7_digit_lut u_lut (.bcd(4'd0), .seg(lut_s[8*k +: 8]));
            end
        end
    endgenerate

    // Display composition from the final BCD value: blanking, sign and overflow
    always_comb begin
        msd_s = 0;
        big_s = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_step_s[4*i +: 4] != 4'd0) begin
                msd_s = i;
                big_s = big_s | (i >= DIGITS);
            end else begin
                big_s = big_s;
            end
        end
        // a negative value also needs the slot above its top digit for the minus
        ovf_s = big_s | (neg_s & ((msd_s + 1) >= DIGITS));
        seg_s = {DIGITS{SEG_OFF}};
        for (int d = 0; d < DIGITS; d++) begin
            if (ovf_s)                          seg_s[8*d +: 8] = SEG_MINUS;
            else if (d <= msd_s)                seg_s[8*d +: 8] = lut_s[8*d +: 8];
            else if (neg_s && d == msd_s + 1)   seg_s[8*d +: 8] = SEG_MINUS;
            else                                seg_s[8*d +: 8] = SEG_OFF;
        end
    end

    // Result registers, loaded on the step that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_seg   <= {DIGITS{SEG_OFF}};
            out_ovf   <= 1'b0;
        end else if (state_r == ST_CONV && last_step_s) begin
            out_valid <= 1'b1;
            out_seg   <= seg_s;
            out_ovf   <= ovf_s;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
